// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, and holds the result until taken.
module mix_columns_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned COL_W     = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam logic [1:0]  CNT_STEP  = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  LAST_GRP  = 2'(NUM_COLS - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state;
  logic [1:0]                     cnt;
  logic                           mode;
  logic [NUM_COLS-1:0][COL_W-1:0] work;   // work[3] holds column 0 (bits 127:96)
  logic [NUM_COLS-1:0][COL_W-1:0] next_work;
  logic [1:0]                     col_idx;
  logic                           last_grp;

  // GF(2^8) multiply by a 4-bit constant, reduction polynomial 0x11b.
  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] a, input logic [3:0] k);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] acc;
    p   = a;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = {p[BYTE_W-2:0], 1'b0} ^ (p[BYTE_W-1] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // One column through the circulant matrix; row r uses the base row rotated right by r.
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col, input logic inv);
    logic [3:0]        k [NUM_COLS];
    logic [BYTE_W-1:0] b [NUM_COLS];
    logic [BYTE_W-1:0] acc;
    logic [COL_W-1:0]  res;
    k[0] = inv ? 4'he : 4'h2;
    k[1] = inv ? 4'hb : 4'h3;
    k[2] = inv ? 4'hd : 4'h1;
    k[3] = inv ? 4'h9 : 4'h1;
    for (int j = 0; j < 4; j++) b[j] = col[COL_W-1-BYTE_W*j -: BYTE_W];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(b[j], k[2'(j - r)]);
      res[COL_W-1-BYTE_W*r -: BYTE_W] = acc;
    end
    return res;
  endfunction

  // Transform the current column group; untouched columns pass through.
  always_comb begin
    next_work = work;
    col_idx   = '0;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx = cnt + 2'(g);
      next_work[2'(2'd3 - col_idx)] = mix_col(work[2'(2'd3 - col_idx)], mode);
    end
  end

  assign last_grp = (cnt == LAST_GRP);
  assign out_data = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode     <= in_inverse;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          work <= next_work;
          cnt  <= cnt + CNT_STEP;
          if (last_grp) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
